// File: rtl/ldtu_bs_pkg.sv
// Shared types and helpers for the LiTe-DTU baseline-subtraction stage.
// Holds the estimator state encoding, baseline-mode constants and the accumulator sizing.
package ldtu_bs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    UPDATE = 2'd2
  } bsl_state_e;

  localparam logic BSL_MODE_MANUAL = 1'b0;
  localparam logic BSL_MODE_AUTO   = 1'b1;

  function automatic int acc_width(input int nbits, input int avg_log2);
    return nbits + avg_log2;
  endfunction

endpackage

// File: rtl/ldtu_bsl_estimator.sv
// Pedestal estimator: averages 2^AVG_LOG2 valid samples into a clamped auto baseline.
// Takes every valid sample while acquiring; invalid cycles simply stretch the acquisition.
module ldtu_bsl_estimator
  import ldtu_bs_pkg::*;
#(
  parameter int NBITS    = 12,
  parameter int BSL_BITS = 8,
  parameter int AVG_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                smp_vld_i,
  input  logic [NBITS-1:0]    smp_dat_i,
  input  logic                calib_start_i,
  output logic [BSL_BITS-1:0] auto_bsl_o,
  output logic                calib_busy_o,
  output logic                calib_done_o
);

  localparam int AW = acc_width(NBITS, AVG_LOG2);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
  localparam logic [NBITS-1:0] BSL_MAX = NBITS'(2**BSL_BITS - 1);

  bsl_state_e          state_q;
  logic [AW-1:0]       acc_q;
  logic [AVG_LOG2-1:0] cnt_q;
  logic [BSL_BITS-1:0] auto_q;
  logic [BSL_BITS-1:0] auto_d;
  logic                busy_q;
  logic                done_q;
  logic [NBITS-1:0]    mean;

  // Truncating divide is just a slice; the clamp keeps a hot pedestal from wrapping.
  assign mean   = acc_q[AW-1:AVG_LOG2];
  assign auto_d = (mean > BSL_MAX) ? BSL_MAX[BSL_BITS-1:0] : mean[BSL_BITS-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      auto_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (calib_start_i) begin
            state_q <= ACQ;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACQ: begin
          if (smp_vld_i) begin
            acc_q <= acc_q + AW'(smp_dat_i);
            cnt_q <= cnt_q + AVG_LOG2'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= UPDATE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        UPDATE: begin
          auto_q  <= auto_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign auto_bsl_o   = auto_q;
  assign calib_busy_o = busy_q;
  assign calib_done_o = done_q;

endmodule

// File: rtl/ldtu_bs_auto.sv
// Baseline subtraction for one ADC channel, manual or auto-estimated baseline.
// Two-cycle latency data_valid -> data_out_valid; no backpressure, one sample per cycle.
module ldtu_bs_auto
  import ldtu_bs_pkg::*;
#(
  parameter int NBITS    = 12,
  parameter int BSL_BITS = 8,
  parameter int AVG_LOG2 = 4,
  parameter int SAT_EN   = 1
) (
  input  logic                DCLK,
  input  logic                rst_b,
  input  logic [NBITS-1:0]    data_in,
  input  logic                data_valid,
  input  logic                bsl_mode,
  input  logic [BSL_BITS-1:0] bsl_manual,
  input  logic                calib_start,
  output logic [NBITS-1:0]    data_out,
  output logic                data_out_valid,
  output logic                underflow,
  output logic [BSL_BITS-1:0] bsl_out,
  output logic                calib_busy,
  output logic                calib_done
);

  logic [NBITS-1:0]    s1_dat_q;
  logic                s1_vld_q;
  logic [NBITS-1:0]    out_dat_q;
  logic                out_vld_q;
  logic                out_uf_q;
  logic [BSL_BITS-1:0] bsl_q;

  logic [BSL_BITS-1:0] auto_bsl;
  logic [BSL_BITS-1:0] bsl_sel;
  logic [NBITS-1:0]    bsl_ext;
  logic [NBITS:0]      diff;
  logic                uf_d;
  logic [NBITS-1:0]    res_d;

  ldtu_bsl_estimator #(
    .NBITS   (NBITS),
    .BSL_BITS(BSL_BITS),
    .AVG_LOG2(AVG_LOG2)
  ) u_est (
    .clk_i        (DCLK),
    .rst_ni       (rst_b),
    .smp_vld_i    (s1_vld_q),
    .smp_dat_i    (s1_dat_q),
    .calib_start_i(calib_start),
    .auto_bsl_o   (auto_bsl),
    .calib_busy_o (calib_busy),
    .calib_done_o (calib_done)
  );

  assign bsl_sel = (bsl_mode == BSL_MODE_AUTO) ? auto_bsl : bsl_manual;
  assign bsl_ext = NBITS'(bsl_sel);

  // Extra MSB of the difference is the borrow, i.e. the underflow flag.
  assign diff  = {1'b0, s1_dat_q} - {1'b0, bsl_ext};
  assign uf_d  = diff[NBITS];
  assign res_d = ((SAT_EN != 0) && uf_d) ? '0 : diff[NBITS-1:0];

  always_ff @(posedge DCLK or negedge rst_b) begin
    if (!rst_b) begin
      s1_dat_q  <= '0;
      s1_vld_q  <= 1'b0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      out_uf_q  <= 1'b0;
      bsl_q     <= '0;
    end else begin
      s1_dat_q  <= data_in;
      s1_vld_q  <= data_valid;
      out_vld_q <= s1_vld_q;
      bsl_q     <= bsl_sel;
      if (s1_vld_q) begin
        out_dat_q <= res_d;
        out_uf_q  <= uf_d;
      end
    end
  end

  assign data_out       = out_dat_q;
  assign data_out_valid = out_vld_q;
  assign underflow      = out_uf_q;
  assign bsl_out        = bsl_q;

endmodule

// File: tb/tb_ldtu_bs_auto.sv
// Bench for ldtu_bs_auto: saturating and wrapping builds side by side against a behavioural model.
// Directed test-plan steps followed by a randomized soak.
module tb_ldtu_bs_auto;

  localparam int NB = 12;
  localparam int BB = 8;
  localparam int AL = 4;
  localparam int NS = 1 << AL;

  logic          DCLK = 1'b0;
  logic          rst_b = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          bsl_mode = 1'b0;
  logic [BB-1:0] bsl_manual = '0;
  logic          calib_start = 1'b0;

  logic [NB-1:0] data_out, data_out_w;
  logic          data_out_valid, data_out_valid_w;
  logic          underflow, underflow_w;
  logic [BB-1:0] bsl_out, bsl_out_w;
  logic          calib_busy, calib_busy_w;
  logic          calib_done, calib_done_w;

  always #5 DCLK = ~DCLK;

  ldtu_bs_auto #(.NBITS(NB), .BSL_BITS(BB), .AVG_LOG2(AL), .SAT_EN(1)) dut (
    .DCLK(DCLK), .rst_b(rst_b), .data_in(data_in), .data_valid(data_valid),
    .bsl_mode(bsl_mode), .bsl_manual(bsl_manual), .calib_start(calib_start),
    .data_out(data_out), .data_out_valid(data_out_valid), .underflow(underflow),
    .bsl_out(bsl_out), .calib_busy(calib_busy), .calib_done(calib_done));

  ldtu_bs_auto #(.NBITS(NB), .BSL_BITS(BB), .AVG_LOG2(AL), .SAT_EN(0)) dut_w (
    .DCLK(DCLK), .rst_b(rst_b), .data_in(data_in), .data_valid(data_valid),
    .bsl_mode(bsl_mode), .bsl_manual(bsl_manual), .calib_start(calib_start),
    .data_out(data_out_w), .data_out_valid(data_out_valid_w), .underflow(underflow_w),
    .bsl_out(bsl_out_w), .calib_busy(calib_busy_w), .calib_done(calib_done_w));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: previous-cycle input sample, output registers, and the
  // calibration as a list of collected samples averaged arithmetically.
  logic          m_s1v;
  int            m_s1d;
  int            m_out, m_out_w, m_bsl, m_auto;
  logic          m_ov, m_uf;
  logic          m_acq, m_upd;
  int            m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1v = 0; m_s1d = 0;
    m_out = 0; m_out_w = 0; m_bsl = 0; m_auto = 0;
    m_ov = 0; m_uf = 0; m_acq = 0; m_upd = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int b;
    int sum;
    b = (bsl_mode == 1'b1) ? m_auto : int'(bsl_manual);
    if (m_s1v) begin
      m_uf    = (m_s1d < b);
      m_out   = m_uf ? 0 : m_s1d - b;
      m_out_w = (m_s1d - b + (1 << NB)) % (1 << NB);
    end
    m_ov  = m_s1v;
    m_bsl = b;
    if (m_upd) begin
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      sum = sum / NS;
      m_auto = (sum > (1 << BB) - 1) ? (1 << BB) - 1 : sum;
      m_upd = 0;
    end else if (m_acq) begin
      if (m_s1v) m_q.push_back(m_s1d);
      if (m_q.size() == NS) begin
        m_acq = 0;
        m_upd = 1;
      end
    end else if (calib_start) begin
      m_acq = 1;
      m_q.delete();
    end
    m_s1v = data_valid;
    m_s1d = int'(data_in);
  endtask

  task automatic check_all();
    chk("data_out", data_out, m_out);
    chk("data_out_valid", data_out_valid, m_ov);
    chk("underflow", underflow, m_uf);
    chk("bsl_out", bsl_out, m_bsl);
    chk("calib_busy", calib_busy, m_acq);
    chk("calib_done", calib_done, m_upd);
    chk("wrap_data_out", data_out_w, m_out_w);
    chk("wrap_underflow", underflow_w, m_uf);
    chk("wrap_valid", data_out_valid_w, m_ov);
  endtask

  task automatic cyc();
    @(posedge DCLK);
    if (!rst_b) model_reset();
    else model_edge();
    #2;
    check_all();
  endtask

  task automatic drive(input logic v, input int d);
    data_valid = v;
    data_in    = NB'(d);
  endtask

  initial begin
    int ndone;
    int nbusy;
    model_reset();
    #1;
    check_all();
    cyc();
    #1 rst_b = 1'b1;

    // manual subtraction, 2-cycle latency
    bsl_mode = 1'b0; bsl_manual = 8'd40;
    drive(1, 1000); cyc();
    drive(0, 0);    cyc();
    chk("manual_960", data_out, 960);
    chk("manual_bsl40", bsl_out, 40);
    chk("manual_nouf", underflow, 0);

    // underflow: saturate vs wrap
    bsl_manual = 8'd50;
    drive(1, 20); cyc();
    drive(0, 0);  cyc();
    chk("sat_zero", data_out, 0);
    chk("sat_uf", underflow, 1);
    chk("wrap_fe2", data_out_w, 12'hFE2);

    // d == b
    drive(1, 50); cyc();
    drive(0, 0);  cyc();
    chk("equal_zero", data_out, 0);
    chk("equal_nouf", underflow, 0);

    // valid gap of 3 cycles
    for (int i = 0; i < 4; i++) begin drive(1, 200 + i); cyc(); end
    for (int i = 0; i < 3; i++) begin drive(0, 999); cyc(); end
    drive(1, 300); cyc();
    chk("gap_hold", data_out, 153);
    for (int i = 0; i < 3; i++) cyc();
    drive(0, 0); cyc(); cyc();

    // calibration: alternating 100/101
    bsl_mode = 1'b1;
    calib_start = 1'b1; cyc(); calib_start = 1'b0;
    ndone = 0;
    for (int i = 0; i < NS; i++) begin
      drive(1, 100 + (i % 2)); cyc(); ndone += int'(calib_done);
    end
    drive(0, 0);
    for (int i = 0; i < 5; i++) begin cyc(); ndone += int'(calib_done); end
    chk("calib1_one_done", ndone, 1);
    chk("calib1_bsl100", bsl_out, 100);
    drive(1, 500); cyc();
    drive(0, 0);   cyc();
    chk("calib1_out400", data_out, 400);

    // clamp, gapped valid, restart request ignored mid-acquisition
    calib_start = 1'b1; cyc(); calib_start = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 2 * NS; i++) begin
      drive((i % 2) == 0, 300);
      if (i == 9) calib_start = 1'b1;
      cyc();
      calib_start = 1'b0;
      nbusy += int'(calib_busy);
    end
    drive(0, 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("clamp_busy_span", nbusy, 2 * NS - 1);
    chk("clamp_bsl255", bsl_out, 255);

    // reset in the middle of an acquisition
    calib_start = 1'b1; cyc(); calib_start = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1, 77); cyc(); end
    #1 rst_b = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_busy0", calib_busy, 0);
    cyc(); cyc();
    #1 rst_b = 1'b1;
    drive(1, 123);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin cyc(); ndone += int'(calib_done); end
    chk("rst_no_done", ndone, 0);
    chk("rst_auto0", bsl_out, 0);
    chk("rst_out123", data_out, 123);

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bsl_mode = ~bsl_mode;
      if ($urandom_range(0, 15) == 0) bsl_manual = BB'($urandom_range(0, 255));
      calib_start = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4095) : $urandom_range(0, 300));
      cyc();
    end
    calib_start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
